// File: rtl/fifo_prog.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    input  logic                  err_clr,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count,
    output logic                  ovf_sticky,
    output logic                  udf_sticky
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  ovf_sticky_q, ovf_sticky_d, udf_sticky_q, udf_sticky_d;
    logic                  wr_acc, rd_acc, ovf_cond, udf_cond;

    assign count       = count_q;
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign ovf_sticky  = ovf_sticky_q;
    assign udf_sticky  = udf_sticky_q;

    always_comb begin
        wr_acc   = wr_en && !full && !flush;
        rd_acc   = rd_en && !empty && !flush;
        ovf_cond = wr_en && full && !flush;
        udf_cond = rd_en && empty && !flush;

        // Explicit wrap so non-power-of-two depths never index past the last entry.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        ovf_sticky_d = ovf_cond || (ovf_sticky_q && !err_clr);
        udf_sticky_d = udf_cond || (udf_sticky_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_ack_q     <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_ack_q     <= wr_acc;
            overflow_q   <= ovf_cond;
            underflow_q  <= udf_cond;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)         dout_q <= '0;
                else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
            end
            assign data_out = dout_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: a standard-read 8-deep and an FWFT 5-deep instance share
// the same stimulus and are each checked against a queue-based reference model.
module tb_fifo_prog;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  af0 = 4'd6, ae0 = 4'd2;
    logic [2:0]  af1 = 3'd4, ae1 = 3'd1;

    logic [15:0] dout0, dout1;
    logic [3:0]  count0;
    logic [2:0]  count1;
    logic ack0, ovf0, udf0, full0, empty0, afl0, ael0, os0, us0;
    logic ack1, ovf1, udf1, full1, empty1, afl1, ael1, os1, us1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .af_thresh(af0), .ae_thresh(ae0), .err_clr(err_clr),
        .data_out(dout0), .wr_ack(ack0), .overflow(ovf0), .underflow(udf0),
        .full(full0), .empty(empty0), .almostfull(afl0), .almostempty(ael0),
        .count(count0), .ovf_sticky(os0), .udf_sticky(us0));

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .wr_en(wr_en),
        .rd_en(rd_en), .af_thresh(af1), .ae_thresh(ae1), .err_clr(err_clr),
        .data_out(dout1), .wr_ack(ack1), .overflow(ovf1), .underflow(udf1),
        .full(full1), .empty(empty1), .almostfull(afl1), .almostempty(ael1),
        .count(count1), .ovf_sticky(os1), .udf_sticky(us1));

    logic [28:0] act0;
    logic [27:0] act1;
    assign act0 = {count0, full0, empty0, afl0, ael0, ack0, ovf0, udf0, os0, us0, dout0};
    assign act1 = {count1, full1, empty1, afl1, ael1, ack1, ovf1, udf1, os1, us1, dout1};

    // Reference model: contents as queues, pulses and sticky flags as plain bits.
    int          depth [2] = '{8, 5};
    logic [15:0] mq [2][$];
    logic        e_ack [2], e_ovf [2], e_udf [2], e_os [2], e_us [2];
    logic [15:0] e_dout0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            e_ack[d] = 1'b0; e_ovf[d] = 1'b0; e_udf[d] = 1'b0;
            e_os[d]  = 1'b0; e_us[d]  = 1'b0;
        end
        e_dout0 = '0;
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic fl,
                              input logic clr, input logic [15:0] din);
        int          sz;
        logic        f, e;
        logic [15:0] w;
        for (int d = 0; d < 2; d++) begin
            sz = mq[d].size();
            f  = (sz == depth[d]);
            e  = (sz == 0);
            if (wr && f && !fl) e_os[d] = 1'b1; else if (clr) e_os[d] = 1'b0;
            if (rd && e && !fl) e_us[d] = 1'b1; else if (clr) e_us[d] = 1'b0;
            if (fl) begin
                mq[d].delete();
                e_ack[d] = 1'b0; e_ovf[d] = 1'b0; e_udf[d] = 1'b0;
            end else begin
                e_ack[d] = wr && !f;
                e_ovf[d] = wr && f;
                e_udf[d] = rd && e;
                if (rd && !e) begin
                    w = mq[d].pop_front();
                    if (d == 0) e_dout0 = w;
                end
                if (wr && !f) mq[d].push_back(din);
            end
        end
    endtask

    function automatic logic [28:0] exp0();
        int sz;
        sz = mq[0].size();
        return {4'(sz), sz == 8, sz == 0, sz >= int'(af0), sz <= int'(ae0),
                e_ack[0], e_ovf[0], e_udf[0], e_os[0], e_us[0], e_dout0};
    endfunction

    function automatic logic [27:0] exp1();
        int sz;
        logic [15:0] hd;
        sz = mq[1].size();
        hd = (sz == 0) ? 16'h0 : mq[1][0];
        return {3'(sz), sz == 5, sz == 0, sz >= int'(af1), sz <= int'(ae1),
                e_ack[1], e_ovf[1], e_udf[1], e_os[1], e_us[1], hd};
    endfunction

    task automatic tick(input logic wr, input logic rd, input logic fl,
                        input logic clr, input logic [15:0] din);
        wr_en = wr; rd_en = rd; flush = fl; err_clr = clr; data_in = din;
        @(posedge clk);
        model_step(wr, rd, fl, clr, din);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_std got %h expected %h", act0, exp0());
        end
        n_chk++;
        if (act1 !== exp1()) begin
            n_fail++; $display("FAIL reset_fwft got %h expected %h", act1, exp1());
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(i));
            n_chk++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL fill_std[%0d] got %h expected %h", i, act0, exp0());
            end
            n_chk++;
            if (act1 !== exp1()) begin
                n_fail++; $display("FAIL fill_fwft[%0d] got %h expected %h", i, act1, exp1());
            end
        end
        n_chk++;
        if (count0 !== 4'd8 || full0 !== 1'b1 || ovf0 !== 1'b1 || os0 !== 1'b1) begin
            n_fail++; $display("FAIL fill_overflow got count=%0d full=%b ovf=%b os=%b expected 8 1 1 1",
                               count0, full0, ovf0, os0);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n_chk++;
            if (act0 !== exp0() || dout0 !== ((i < 8) ? 16'(i + 1) : 16'h0008)) begin
                n_fail++; $display("FAIL drain_std[%0d] got %h expected %h", i, act0, exp0());
            end
            n_chk++;
            if (act1 !== exp1()) begin
                n_fail++; $display("FAIL drain_fwft[%0d] got %h expected %h", i, act1, exp1());
            end
        end
        n_chk++;
        if (udf0 !== 1'b1 || empty0 !== 1'b1 || us0 !== 1'b1) begin
            n_fail++; $display("FAIL drain_underflow got udf=%b empty=%b us=%b expected 1 1 1", udf0, empty0, us0);
        end
    endtask

    task automatic test_fwft_wrap();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 16'hA5A5);
        n_chk++;
        if (act1 !== exp1() || dout1 !== 16'hA5A5) begin
            n_fail++; $display("FAIL fwft_first got %h expected %h", act1, exp1());
        end
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
            else            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n_chk++;
            if (act1 !== exp1()) begin
                n_fail++; $display("FAIL fwft_wrap[%0d] got %h expected %h", i, act1, exp1());
            end
            n_chk++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL std_wrap[%0d] got %h expected %h", i, act0, exp0());
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h100 + i));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0200);
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd3) begin
            n_fail++; $display("FAIL simul_mid got %h expected %h", act0, exp0());
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
            n_chk++;
            if (act0 !== exp0() || act1 !== exp1()) begin
                n_fail++; $display("FAIL simul_order[%0d] got %h/%h expected %h/%h", i, act0, act1, exp0(), exp1());
            end
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h300 + i));
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0399);
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd7 || ovf0 !== 1'b1 || dout0 !== 16'h0300) begin
            n_fail++; $display("FAIL simul_full got %h expected %h", act0, exp0());
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 16'h0444);
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd1 || udf0 !== 1'b1 || ack0 !== 1'b1) begin
            n_fail++; $display("FAIL simul_empty got %h expected %h", act0, exp0());
        end
        n_chk++;
        if (act1 !== exp1() || dout1 !== 16'h0444) begin
            n_fail++; $display("FAIL simul_empty_fwft got %h expected %h", act1, exp1());
        end
    endtask

    task automatic test_thresholds();
        af0 = 4'd6; ae0 = 4'd2;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(i));
        n_chk++;
        if (act0 !== exp0() || ael0 !== 1'b1 || afl0 !== 1'b0) begin
            n_fail++; $display("FAIL thresh_ae got %h expected %h", act0, exp0());
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(i));
        n_chk++;
        if (act0 !== exp0() || afl0 !== 1'b1 || ael0 !== 1'b0) begin
            n_fail++; $display("FAIL thresh_af got %h expected %h", act0, exp0());
        end
        af0 = 4'd7;
        #1;
        n_chk++;
        if (act0 !== exp0() || afl0 !== 1'b0) begin
            n_fail++; $display("FAIL thresh_change got %h expected %h", act0, exp0());
        end
    endtask

    task automatic test_flush_errclr();
        tick(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h500 + i));
        tick(1'b1, 1'b0, 1'b1, 1'b0, 16'h0BAD);
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd0 || empty0 !== 1'b1 || ack0 !== 1'b0) begin
            n_fail++; $display("FAIL flush got %h expected %h", act0, exp0());
        end
        n_chk++;
        if (act1 !== exp1() || dout1 !== 16'h0) begin
            n_fail++; $display("FAIL flush_fwft got %h expected %h", act1, exp1());
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        n_chk++;
        if (act0 !== exp0() || os0 !== 1'b0 || us0 !== 1'b0) begin
            n_fail++; $display("FAIL err_clr got %h expected %h", act0, exp0());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h600 + i));
        wr_en = 1'b1; data_in = 16'h0677;
        #2 rst = 1'b1;
        #1 model_reset();
        n_chk++;
        if (act0 !== exp0() || count0 !== 4'd0 || dout0 !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid_std got %h expected %h", act0, exp0());
        end
        n_chk++;
        if (act1 !== exp1()) begin
            n_fail++; $display("FAIL reset_mid_fwft got %h expected %h", act1, exp1());
        end
        wr_en = 1'b0;
        #2 rst = 1'b0;
    endtask

    task automatic test_random();
        logic wr, rd, fl, clr;
        for (int i = 0; i < 400; i++) begin
            if (i % 100 < 50) begin
                wr = ($urandom_range(3) != 0); rd = ($urandom_range(3) == 0);
            end else begin
                wr = ($urandom_range(3) == 0); rd = ($urandom_range(3) != 0);
            end
            fl  = ($urandom_range(39) == 0);
            clr = ($urandom_range(19) == 0);
            if ($urandom_range(15) == 0) begin
                af0 = 4'($urandom_range(9)); ae0 = 4'($urandom_range(9));
                af1 = 3'($urandom_range(6)); ae1 = 3'($urandom_range(6));
            end
            tick(wr, rd, fl, clr, 16'($urandom));
            n_chk++;
            if (act0 !== exp0()) begin
                n_fail++; $display("FAIL random_std[%0d] got %h expected %h", i, act0, exp0());
            end
            n_chk++;
            if (act1 !== exp1()) begin
                n_fail++; $display("FAIL random_fwft[%0d] got %h expected %h", i, act1, exp1());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_fwft_wrap();
        test_simultaneous();
        test_thresholds();
        test_flush_errclr();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
